// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin grant arbiter.
// Imported by the rotate-priority finder and the arbiter top level.
package rr_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot2(input logic [1:0] idx);
    logic [N_REQ-1:0] vec;
    case (idx)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority finder: first set bit of req searching
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  logic [N_REQ-1:0] rot_s;
  logic [1:0]       off_s;

  // Rotate right by ptr so bit 0 of rot_s is the highest-priority requester.
  always_comb begin
    rot_s = req;
    case (ptr)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0],   req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
  end

  // Priority-encode the rotated vector, then un-rotate the offset.
  always_comb begin
    off_s = 2'd0;
    found = 1'b1;
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else if (rot_s[3]) begin
      off_s = 2'd3;
    end else begin
      off_s = 2'd0;
      found = 1'b0;
    end
    idx = ptr + off_s;
  end

endmodule

// File: rtl/rr_grant_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional per-tenure hold limit (MAX_HOLD = 0 means unlimited).
module rr_grant_arb4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [1:0]       grant_id
);

  localparam logic [HOLD_W-1:0] HOLD_LIM       = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT       = 8'hFF;
  localparam logic              HOLD_UNLIMITED = (MAX_HOLD == 32'd0);

  arb_state_t        state_r, state_s;
  logic [1:0]        ptr_r, ptr_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [N_REQ-1:0]  grant_r, grant_s;
  logic [1:0]        grant_id_r, grant_id_s;
  logic              grant_valid_r;

  logic [1:0]        nxt_ptr_s;
  logic              cur_found_s, nxt_found_s;
  logic [1:0]        cur_idx_s, nxt_idx_s;
  logic              owner_req_s;
  logic              exhausted_s;

  assign nxt_ptr_s = grant_id_r + 2'd1;

  // Idle arbitration uses the stored pointer; handoff uses owner+1.
  rr_pick4 u_pick_cur (
    .req   (req),
    .ptr   (ptr_r),
    .found (cur_found_s),
    .idx   (cur_idx_s)
  );

  rr_pick4 u_pick_nxt (
    .req   (req),
    .ptr   (nxt_ptr_s),
    .found (nxt_found_s),
    .idx   (nxt_idx_s)
  );

  // Owner status and tenure-limit detection.
  always_comb begin
    owner_req_s = req[grant_id_r];
    if (HOLD_UNLIMITED) begin
      exhausted_s = 1'b0;
    end else begin
      exhausted_s = (hold_cnt_r >= HOLD_LIM);
    end
  end

  // Next-state, pointer, hold counter and grant computation.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    grant_s    = grant_r;
    grant_id_s = grant_id_r;
    case (state_r)
      IDLE: begin
        if (cur_found_s) begin
          state_s    = BUSY;
          grant_s    = onehot2(cur_idx_s);
          grant_id_s = cur_idx_s;
          hold_cnt_s = 8'd1;
        end else begin
          state_s    = IDLE;
          grant_s    = 4'b0000;
          grant_id_s = 2'd0;
        end
      end
      BUSY: begin
        if (!owner_req_s || exhausted_s) begin
          // Owner sits last in the new search order, so a lone owner is re-granted.
          ptr_s = nxt_ptr_s;
          if (nxt_found_s) begin
            state_s    = BUSY;
            grant_s    = onehot2(nxt_idx_s);
            grant_id_s = nxt_idx_s;
            hold_cnt_s = 8'd1;
          end else begin
            state_s    = IDLE;
            grant_s    = 4'b0000;
            grant_id_s = 2'd0;
            hold_cnt_s = 8'd0;
          end
        end else if (hold_cnt_r != HOLD_SAT) begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        ptr_s      = 2'd0;
        hold_cnt_s = 8'd0;
        grant_s    = 4'b0000;
        grant_id_s = 2'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= 2'd0;
      hold_cnt_r    <= 8'd0;
      grant_r       <= 4'b0000;
      grant_id_r    <= 2'd0;
      grant_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      hold_cnt_r    <= hold_cnt_s;
      grant_r       <= grant_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= (state_s == BUSY);
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_rr_grant_arb4.sv
// Scoreboard bench for rr_grant_arb4: three instances (MAX_HOLD 8, 4, 0) share
// req/rst; a behavioural model pushes expectations, sampled outputs pop them.
module tb_rr_grant_arb4;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] grant_8, grant_4, grant_0;
  logic       valid_8, valid_4, valid_0;
  logic [1:0] id_8, id_4, id_0;

  logic [6:0] obs [3];
  assign obs[0] = {grant_8, valid_8, id_8};
  assign obs[1] = {grant_4, valid_4, id_4};
  assign obs[2] = {grant_0, valid_0, id_0};

  rr_grant_arb4 #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_8), .grant_valid(valid_8), .grant_id(id_8));
  rr_grant_arb4 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_4), .grant_valid(valid_4), .grant_id(id_4));
  rr_grant_arb4 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_0), .grant_valid(valid_0), .grant_id(id_0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int mh      [3] = '{8, 4, 0};
  bit m_busy  [3];
  int m_ptr   [3];
  int m_hold  [3];
  int m_owner [3];

  logic [20:0] sb_q [$];

  int wait_c   [2][4];
  int max_wait [2];

  task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs_v, exp_v, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [3:0] r, input logic rv);
    int w;
    if (rv) begin
      m_busy[k] = 1'b0; m_ptr[k] = 0; m_hold[k] = 0; m_owner[k] = 0;
    end else if (!m_busy[k]) begin
      w = first_from(r, m_ptr[k]);
      if (w >= 0) begin
        m_busy[k] = 1'b1; m_owner[k] = w; m_hold[k] = 1;
      end
    end else if (r[m_owner[k]] && (mh[k] == 0 || m_hold[k] < mh[k])) begin
      if (m_hold[k] < 255) m_hold[k]++;
    end else begin
      m_ptr[k] = (m_owner[k] + 1) % 4;
      w = first_from(r, m_ptr[k]);
      if (w >= 0) begin
        m_owner[k] = w; m_hold[k] = 1;
      end else begin
        m_busy[k] = 1'b0; m_owner[k] = 0; m_hold[k] = 0;
      end
    end
  endtask

  task automatic clear_waits();
    for (int k = 0; k < 2; k++) begin
      max_wait[k] = 0;
      for (int i = 0; i < 4; i++) wait_c[k][i] = 0;
    end
  endtask

  // One clock: drive at negedge, push model expectation, pop and compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic rv);
    logic [20:0] e;
    logic [6:0]  ek;
    logic [3:0]  eg;
    @(negedge clk);
    req = r;
    rst = rv;
    for (int k = 0; k < 3; k++) begin
      model_step(k, r, rv);
      eg = m_busy[k] ? (4'b0001 << m_owner[k]) : 4'b0000;
      e[k*7 +: 7] = {eg, m_busy[k], m_owner[k][1:0]};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_val("sb_depth", sb_q.size(), 1);
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      ek = e[k*7 +: 7];
      check_val($sformatf("grant_mh%0d", mh[k]), obs[k][6:3], ek[6:3]);
      check_val($sformatf("valid_mh%0d", mh[k]), obs[k][2], ek[2]);
      check_val($sformatf("id_mh%0d", mh[k]), obs[k][1:0], ek[1:0]);
      check_val($sformatf("onehot0_mh%0d", mh[k]), $onehot0(obs[k][6:3]), 1);
      check_val($sformatf("valid_or_mh%0d", mh[k]), obs[k][2], |obs[k][6:3]);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i] && !rv && !obs[k][3+i]) wait_c[k][i]++;
        else wait_c[k][i] = 0;
        if (wait_c[k][i] > max_wait[k]) max_wait[k] = wait_c[k][i];
      end
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    req = 4'b0000;
    rst = 1'b1;
    clear_waits();

    // Reset state
    cycle(4'b0000, 1'b1);
    check_val("rst_grant", grant_8, 4'b0000);
    check_val("rst_valid", valid_8, 1'b0);
    check_val("rst_id", id_8, 2'd0);

    // All requesting, MAX_HOLD 8: 8 cycles each, rotating and wrapping
    for (int t = 0; t < 40; t++) begin
      cycle(4'b1111, 1'b0);
      exp_g = 4'b0001 << ((t / 8) % 4);
      check_val("rr8_seq", grant_8, exp_g);
      check_val("rr8_valid", valid_8, 1'b1);
    end

    // Lone requester 2, MAX_HOLD 4: no bubble on forced release
    cycle(4'b0000, 1'b1);
    for (int t = 0; t < 13; t++) begin
      cycle(4'b0100, 1'b0);
      check_val("solo_mh4", grant_4, 4'b0100);
    end
    cycle(4'b0000, 1'b0);
    check_val("solo_drop", grant_4, 4'b0000);

    // Owner 0 releases while 1 and 3 wait: search from ptr 1 gives 1
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    cycle(4'b1011, 1'b0);
    cycle(4'b1010, 1'b0);
    check_val("handoff_grant", grant_0, 4'b0010);
    check_val("handoff_id", id_0, 2'd1);

    // Unlimited tenure: owner 1 keeps grant for 300 cycles
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b0);
    for (int t = 0; t < 300; t++) begin
      cycle(4'b0011, 1'b0);
      check_val("unlim_hold", grant_0, 4'b0010);
    end

    // Reset mid-tenure while requester 3 owns
    cycle(4'b0000, 1'b1);
    for (int t = 0; t < 26; t++) cycle(4'b1111, 1'b0);
    check_val("pre_rst_owner3", grant_8, 4'b1000);
    cycle(4'b1111, 1'b1);
    check_val("midrst_grant", grant_8, 4'b0000);
    check_val("midrst_id", id_8, 2'd0);
    cycle(4'b1111, 1'b0);
    check_val("post_rst_first", grant_8, 4'b0001);

    // Random traffic with starvation bounds
    cycle(4'b0000, 1'b1);
    clear_waits();
    for (int t = 0; t < 10000; t++) begin
      cycle(4'($urandom_range(0, 15)), 1'b0);
    end
    check_val("starve_mh8", (max_wait[0] <= 3 * 8 + 3), 1);
    check_val("starve_mh4", (max_wait[1] <= 3 * 4 + 3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
